// File: rtl/dma_bus_master_if.sv
// Data-memory bus between the DMA master and the arbiter/memory side.
interface dma_bus_master_if;
    logic        bus_req;
    logic        bus_gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        accessable;

    modport master (output bus_req, rd, wr, addr, wdata,
                    input  bus_gnt, rdata, accessable);
    modport slave  (input  bus_req, rd, wr, addr, wdata,
                    output bus_gnt, rdata, accessable);
endinterface

// File: rtl/dma_bus_master.sv
// Word-copy DMA master: reads a word, writes it, repeats len times on the shared data bus.
// Optional completion/error interrupt enabled by defining DMA_BUS_MASTER_IRQ_EN.
module dma_bus_master #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    dma_bus_master_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      err_addr,
    output logic             irq,
    input  logic             irq_clr
);
    typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE, ERR} state_t;

    state_t           state, state_next;
    logic [31:0]      cur_src, cur_dst, buffer;
    logic [LEN_W-1:0] remaining;
    logic             accept, misaligned, rd_ok, wr_ok, fail;

    assign accept     = (state == IDLE) && start;
    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
    assign rd_ok      = (state == RD) && bus.bus_gnt && bus.accessable;
    assign wr_ok      = (state == WR) && bus.bus_gnt && bus.accessable;
    assign fail       = ((state == RD) || (state == WR)) && bus.bus_gnt && !bus.accessable;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        bus.bus_req = 1'b0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = 32'h0;
        bus.wdata   = 32'h0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)      state_next = DONE;
                    else if (misaligned) state_next = ERR;
                    else                 state_next = REQ;
                end
            end
            REQ: begin
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) state_next = RD;
            end
            RD: begin
                bus.bus_req = 1'b1;
                bus.rd      = bus.bus_gnt;
                bus.addr    = cur_src;
                if (bus.bus_gnt) state_next = bus.accessable ? WR : ERR;
            end
            WR: begin
                bus.bus_req = 1'b1;
                bus.wr      = bus.bus_gnt;
                bus.addr    = cur_dst;
                bus.wdata   = buffer;
                if (bus.bus_gnt) begin
                    if (!bus.accessable)              state_next = ERR;
                    else if (remaining == LEN_W'(1))  state_next = DONE;
                    else                              state_next = RD;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer counters, word buffer and error capture; gnt low freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_src   <= 32'h0;
            cur_dst   <= 32'h0;
            remaining <= '0;
            buffer    <= 32'h0;
            err       <= 1'b0;
            err_addr  <= 32'h0;
        end else begin
            if (accept) begin
                cur_src   <= src_addr;
                cur_dst   <= dst_addr;
                remaining <= len;
                err       <= 1'b0;
                err_addr  <= 32'h0;
                if ((len != '0) && misaligned) begin
                    err      <= 1'b1;
                    err_addr <= (src_addr[1:0] != 2'b00) ? src_addr : dst_addr;
                end
            end
            if (rd_ok) buffer <= bus.rdata;
            if (wr_ok) begin
                cur_src   <= cur_src + 32'd4;
                cur_dst   <= cur_dst + 32'd4;
                remaining <= remaining - LEN_W'(1);
            end
            if (fail) begin
                err      <= 1'b1;
                err_addr <= (state == RD) ? cur_src : cur_dst;
            end
        end
    end

`ifdef DMA_BUS_MASTER_IRQ_EN
    // Set takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              irq <= 1'b0;
        else if ((state == DONE) || (state == ERR)) irq <= 1'b1;
        else if (irq_clr)                       irq <= 1'b0;
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule
